// File: rtl/frv_mtimer.sv
// Machine timer (mtime/mtimecmp) and software-interrupt (msip) source on a
// req/gnt slave bus with a single outstanding response.
module frv_mtimer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        mmio_req,
  output logic        mmio_gnt,
  input  logic        mmio_wen,
  input  logic [3:0]  mmio_strb,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  output logic        mmio_rsp_valid,
  input  logic        mmio_rsp_ready,
  output logic [31:0] mmio_rsp_rdata,
  output logic        mmio_rsp_error,
  output logic [63:0] mtime,
  output logic        ti_pending,
  output logic        sw_pending
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  localparam logic [2:0] SEL_MTIME_LO = 3'd0;
  localparam logic [2:0] SEL_MTIME_HI = 3'd1;
  localparam logic [2:0] SEL_CMP_LO   = 3'd2;
  localparam logic [2:0] SEL_CMP_HI   = 3'd3;
  localparam logic [2:0] SEL_MSIP     = 3'd4;

  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      cmp_q, cmp_d;
  logic             msip_q, msip_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ti_q, ti_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_error_q, rsp_error_d;

  logic             accept;
  logic             hit;
  logic             wr;
  logic [2:0]       sel;
  logic             tick;
  logic [31:0]      rd_val;

  // Byte-lane merge of write data into an existing 32-bit word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
    end
    return res;
  endfunction

  // Only one response may be outstanding; accept again as the current one drains.
  assign mmio_gnt = !rsp_valid_q || mmio_rsp_ready;
  assign accept   = mmio_req && mmio_gnt;
  assign hit      = (mmio_addr[31:5] == BASE_ADDR[31:5]) && (mmio_addr[1:0] == 2'b00);
  assign sel      = mmio_addr[4:2];
  assign wr       = accept && mmio_wen && hit;
  assign tick     = (cnt_q == CNT_MAX);

  // Read mux over the current (pre-write) register values.
  always_comb begin
    rd_val = 32'h0;
    case (sel)
      SEL_MTIME_LO: rd_val = mtime_q[31:0];
      SEL_MTIME_HI: rd_val = mtime_q[63:32];
      SEL_CMP_LO:   rd_val = cmp_q[31:0];
      SEL_CMP_HI:   rd_val = cmp_q[63:32];
      SEL_MSIP:     rd_val = {31'h0, msip_q};
      default:      rd_val = 32'h0;
    endcase
  end

  // Next-state for timer, compare, msip and the response channel.
  always_comb begin
    mtime_d     = mtime_q;
    cmp_d       = cmp_q;
    msip_d      = msip_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    ti_d        = (mtime_q >= cmp_q);

    // A software write to either mtime half overrides this cycle's tick.
    if (wr && (sel == SEL_MTIME_LO)) begin
      mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], mmio_wdata, mmio_strb)};
      cnt_d   = '0;
    end else if (wr && (sel == SEL_MTIME_HI)) begin
      mtime_d = {merge_bytes(mtime_q[63:32], mmio_wdata, mmio_strb), mtime_q[31:0]};
      cnt_d   = '0;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
      cnt_d   = '0;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
    end

    if (wr && (sel == SEL_CMP_LO)) cmp_d[31:0]  = merge_bytes(cmp_q[31:0], mmio_wdata, mmio_strb);
    if (wr && (sel == SEL_CMP_HI)) cmp_d[63:32] = merge_bytes(cmp_q[63:32], mmio_wdata, mmio_strb);
    if (wr && (sel == SEL_MSIP) && mmio_strb[0]) msip_d = mmio_wdata[0];

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_error_d = !hit;
      rsp_rdata_d = (mmio_wen || !hit) ? 32'h0 : rd_val;
    end else if (rsp_valid_q && mmio_rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_rdata_d = 32'h0;
    end
  end

  // State registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      mtime_q     <= 64'h0;
      cmp_q       <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      cnt_q       <= '0;
      ti_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      cmp_q       <= cmp_d;
      msip_q      <= msip_d;
      cnt_q       <= cnt_d;
      ti_q        <= ti_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign mmio_rsp_valid = rsp_valid_q;
  assign mmio_rsp_rdata = rsp_rdata_q;
  assign mmio_rsp_error = rsp_error_q;
  assign mtime          = mtime_q;
  assign ti_pending     = ti_q;
  assign sw_pending     = msip_q;

endmodule

// File: tb/tb_frv_mtimer.sv
// Directed bench for frv_mtimer: register map table plus timer/handshake sequences.
module tb_frv_mtimer;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        req, req4, wen, rsp_ready;
  logic [3:0]  strb;
  logic [31:0] addr, wdata;

  logic        gnt, rsp_valid, err, ti, sw;
  logic [31:0] rdata;
  logic [63:0] mtime;
  logic        gnt4, rsp_valid4, err4, ti4, sw4;
  logic [31:0] rdata4;
  logic [63:0] mtime4;

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  frv_mtimer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .mmio_req(req), .mmio_gnt(gnt),
    .mmio_wen(wen), .mmio_strb(strb), .mmio_addr(addr), .mmio_wdata(wdata),
    .mmio_rsp_valid(rsp_valid), .mmio_rsp_ready(rsp_ready),
    .mmio_rsp_rdata(rdata), .mmio_rsp_error(err),
    .mtime(mtime), .ti_pending(ti), .sw_pending(sw)
  );

  frv_mtimer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
    .g_clk(g_clk), .g_resetn(g_resetn), .mmio_req(req4), .mmio_gnt(gnt4),
    .mmio_wen(wen), .mmio_strb(strb), .mmio_addr(addr), .mmio_wdata(wdata),
    .mmio_rsp_valid(rsp_valid4), .mmio_rsp_ready(rsp_ready),
    .mmio_rsp_rdata(rdata4), .mmio_rsp_error(err4),
    .mtime(mtime4), .ti_pending(ti4), .sw_pending(sw4)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_sw;
  } vec_t;

  vec_t tbl [28];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One access with rsp_ready high; called just after a negedge, returns at the
  // negedge following the accepting clock edge with the response sampled.
  task automatic bus(input bit use4, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     output logic [31:0] rd, output logic er, output logic vld);
    int k;
    wen = w; addr = a; wdata = d; strb = be;
    if (use4) req4 = 1'b1; else req = 1'b1;
    k = 0;
    #1;
    while (((use4 ? gnt4 : gnt) !== 1'b1) && k < 20) begin
      @(negedge g_clk);
      k++;
    end
    if (k >= 20) chk("gnt_timeout", 64'(k), 64'(0));
    @(posedge g_clk);
    @(negedge g_clk);
    req = 1'b0; req4 = 1'b0;
    rd  = use4 ? rdata4 : rdata;
    er  = use4 ? err4 : err;
    vld = use4 ? rsp_valid4 : rsp_valid;
  endtask

  logic [31:0] rd;
  logic        er, vld;
  int          n;

  initial begin
    tbl[0]  = '{1'b0, BASE + 32'h08, 32'h0,         4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, BASE + 32'h0C, 32'h0,         4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, BASE + 32'h10, 32'h0,         4'hF, 32'h0,         1'b0, 1'b0};
    tbl[3]  = '{1'b0, BASE + 32'h14, 32'h0,         4'hF, 32'h0,         1'b0, 1'b0};
    tbl[4]  = '{1'b0, BASE + 32'h1C, 32'h0,         4'hF, 32'h0,         1'b0, 1'b0};
    tbl[5]  = '{1'b1, BASE + 32'h04, 32'h0,         4'hF, 32'h0,         1'b0, 1'b0};
    tbl[6]  = '{1'b1, BASE + 32'h00, 32'h0000_1000, 4'hF, 32'h0,         1'b0, 1'b0};
    tbl[7]  = '{1'b0, BASE + 32'h00, 32'h0,         4'hF, 32'h0000_1000, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, BASE + 32'h00, 32'h0,         4'hF, 32'h0000_1001, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, BASE + 32'h04, 32'h0,         4'hF, 32'h0,         1'b0, 1'b0};
    tbl[10] = '{1'b1, BASE + 32'h08, 32'h1234_5678, 4'hF, 32'h0,         1'b0, 1'b0};
    tbl[11] = '{1'b1, BASE + 32'h08, 32'hAABB_CCDD, 4'h2, 32'h0,         1'b0, 1'b0};
    tbl[12] = '{1'b0, BASE + 32'h08, 32'h0,         4'hF, 32'h1234_CC78, 1'b0, 1'b0};
    tbl[13] = '{1'b1, BASE + 32'h0C, 32'h5566_7788, 4'h5, 32'h0,         1'b0, 1'b0};
    tbl[14] = '{1'b0, BASE + 32'h0C, 32'h0,         4'hF, 32'hFF66_FF88, 1'b0, 1'b0};
    tbl[15] = '{1'b0, BASE + 32'h22, 32'h0,         4'hF, 32'h0,         1'b1, 1'b0};
    tbl[16] = '{1'b0, BASE + 32'h40, 32'h0,         4'hF, 32'h0,         1'b1, 1'b0};
    tbl[17] = '{1'b0, BASE + 32'h0A, 32'h0,         4'hF, 32'h0,         1'b1, 1'b0};
    tbl[18] = '{1'b1, BASE + 32'h28, 32'h0,         4'hF, 32'h0,         1'b1, 1'b0};
    tbl[19] = '{1'b0, BASE + 32'h08, 32'h0,         4'hF, 32'h1234_CC78, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 32'h0000_2008, 32'h0,         4'hF, 32'h0,         1'b1, 1'b0};
    tbl[21] = '{1'b0, BASE + 32'h08, 32'h0,         4'hF, 32'h1234_CC78, 1'b0, 1'b0};
    tbl[22] = '{1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b0, 1'b1};
    tbl[23] = '{1'b0, BASE + 32'h10, 32'h0,         4'hF, 32'h1,         1'b0, 1'b1};
    tbl[24] = '{1'b1, BASE + 32'h10, 32'h0,         4'h0, 32'h0,         1'b0, 1'b1};
    tbl[25] = '{1'b0, BASE + 32'h10, 32'h0,         4'hF, 32'h1,         1'b0, 1'b1};
    tbl[26] = '{1'b1, BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b0, 1'b1};
    tbl[27] = '{1'b0, BASE + 32'h14, 32'h0,         4'hF, 32'h0,         1'b0, 1'b1};

    g_resetn = 1'b0; req = 1'b0; req4 = 1'b0; wen = 1'b0; strb = 4'h0;
    addr = 32'h0; wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge g_clk);
    g_resetn = 1'b1;
    #1;
    chk("rst_mtime", mtime, 64'h0);
    chk("rst_ti", 64'(ti), 64'h0);
    chk("rst_sw", 64'(sw), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_gnt", 64'(gnt), 64'h1);
    @(negedge g_clk);
    chk("mtime_1", mtime, 64'h1);
    @(negedge g_clk);
    chk("mtime_2", mtime, 64'h2);

    // Register map, byte strobes, error decode, msip.
    for (int i = 0; i < 28; i++) begin
      bus(1'b0, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, er, vld);
      chk($sformatf("vec%0d_valid", i), 64'(vld), 64'h1);
      chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(tbl[i].exp_rdata));
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(tbl[i].exp_err));
      chk($sformatf("vec%0d_sw", i), 64'(sw), 64'(tbl[i].exp_sw));
    end
    chk("tbl_ti", 64'(ti), 64'h0);

    // Compare: cmp=0x10, mtime restarted at 0.
    bus(1'b0, 1'b1, BASE + 32'h04, 32'h0, 4'hF, rd, er, vld);
    bus(1'b0, 1'b1, BASE + 32'h00, 32'h0, 4'hF, rd, er, vld);
    bus(1'b0, 1'b1, BASE + 32'h0C, 32'h0, 4'hF, rd, er, vld);
    bus(1'b0, 1'b1, BASE + 32'h08, 32'h10, 4'hF, rd, er, vld);
    chk("cmp_mtime_start", mtime, 64'h2);
    chk("cmp_ti_low", 64'(ti), 64'h0);
    n = 0;
    while (mtime != 64'h10 && n < 40) begin
      @(negedge g_clk);
      n++;
    end
    chk("cmp_reach_cycles", 64'(n), 64'd14);
    chk("cmp_ti_at_reach", 64'(ti), 64'h0);
    @(negedge g_clk);
    chk("cmp_ti_rise", 64'(ti), 64'h1);
    bus(1'b0, 1'b1, BASE + 32'h08, 32'h100, 4'hF, rd, er, vld);
    chk("cmp_ti_hold", 64'(ti), 64'h1);
    @(negedge g_clk);
    chk("cmp_ti_fall", 64'(ti), 64'h0);

    // Carry from low half, then full 64-bit wrap.
    bus(1'b0, 1'b1, BASE + 32'h04, 32'h0, 4'hF, rd, er, vld);
    bus(1'b0, 1'b1, BASE + 32'h00, 32'hFFFF_FFFF, 4'hF, rd, er, vld);
    chk("carry_pre", mtime, 64'h0000_0000_FFFF_FFFF);
    @(negedge g_clk);
    chk("carry_post", mtime, 64'h0000_0001_0000_0000);
    bus(1'b0, 1'b1, BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, rd, er, vld);
    bus(1'b0, 1'b1, BASE + 32'h00, 32'hFFFF_FFFE, 4'hF, rd, er, vld);
    chk("wrap_pre", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge g_clk);
    chk("wrap_max", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge g_clk);
    chk("wrap_zero", mtime, 64'h0);

    // Backpressure: response held, second request stalled until ready.
    rsp_ready = 1'b0;
    wen = 1'b0; strb = 4'hF; wdata = 32'h0; addr = BASE + 32'h08; req = 1'b1;
    #1;
    chk("bp_gnt_idle", 64'(gnt), 64'h1);
    @(posedge g_clk);
    @(negedge g_clk);
    addr = BASE + 32'h10;
    #1;
    chk("bp_valid", 64'(rsp_valid), 64'h1);
    chk("bp_rdata", 64'(rdata), 64'h100);
    chk("bp_gnt_low", 64'(gnt), 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge g_clk);
      chk($sformatf("bp_hold%0d_valid", k), 64'(rsp_valid), 64'h1);
      chk($sformatf("bp_hold%0d_rdata", k), 64'(rdata), 64'h100);
      chk($sformatf("bp_hold%0d_err", k), 64'(err), 64'h0);
      chk($sformatf("bp_hold%0d_gnt", k), 64'(gnt), 64'h0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_gnt_ready", 64'(gnt), 64'h1);
    @(posedge g_clk);
    @(negedge g_clk);
    req = 1'b0;
    chk("bp_second_valid", 64'(rsp_valid), 64'h1);
    chk("bp_second_rdata", 64'(rdata), 64'h1);
    @(negedge g_clk);
    chk("bp_drained", 64'(rsp_valid), 64'h0);

    // Asynchronous reset while a response is pending.
    rsp_ready = 1'b0;
    wen = 1'b0; addr = BASE + 32'h08; req = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    req = 1'b0;
    chk("arst_pre_valid", 64'(rsp_valid), 64'h1);
    #2 g_resetn = 1'b0;
    #1;
    chk("arst_valid", 64'(rsp_valid), 64'h0);
    chk("arst_rdata", 64'(rdata), 64'h0);
    chk("arst_mtime", mtime, 64'h0);
    chk("arst_sw", 64'(sw), 64'h0);
    @(negedge g_clk);
    rsp_ready = 1'b1;
    g_resetn = 1'b1;
    #1;

    // Prescaler of 4 and restart of the count on an mtime write.
    chk("ps4_rst", mtime4, 64'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge g_clk);
      chk($sformatf("ps4_tick%0d", k), mtime4, 64'(k / 4));
    end
    repeat (2) @(negedge g_clk);
    bus(1'b1, 1'b1, BASE + 32'h00, 32'h50, 4'hF, rd, er, vld);
    chk("ps4_wr_valid", 64'(vld), 64'h1);
    chk("ps4_wr", mtime4, 64'h50);
    for (int k = 1; k <= 4; k++) begin
      @(negedge g_clk);
      chk($sformatf("ps4_restart%0d", k), mtime4, (k < 4) ? 64'h50 : 64'h51);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
